// File: rtl/demux_1t4_buf_pkg.sv
// Shared types and sizing helpers for the buffered 1-to-4 demultiplexer.
package carp_demux_pkg;

  typedef logic [1:0] chan_sel_t;

  localparam int NUM_CHAN = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/demux_1t4_buf_chan_fifo.sv
// Per-channel FIFO: registered storage, wrapping pointers and a separate occupancy count.
module chan_fifo
  import carp_demux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == CW'(0));
  assign cnt       = cnt_q;
  // Flags come from the registered count, so a pop never frees space for a same-cycle push.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    if (empty) begin
      head = '0;
    end else begin
      head = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/demux_1t4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input routed by IN_SEL into four
// independent channel FIFOs so a stalled consumer never blocks the others.
module demux_1t4_buf
  import carp_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    IN_VALID,
  output logic                                    IN_READY,
  input  chan_sel_t                               IN_SEL,
  input  logic [WIDTH-1:0]                        IN_DATA,
  output logic [NUM_CHAN-1:0]                     OUT_VALID,
  input  logic [NUM_CHAN-1:0]                     OUT_READY,
  output logic [WIDTH-1:0]                        OUT_DATA0,
  output logic [WIDTH-1:0]                        OUT_DATA1,
  output logic [WIDTH-1:0]                        OUT_DATA2,
  output logic [WIDTH-1:0]                        OUT_DATA3,
  output logic [NUM_CHAN*cnt_width(DEPTH)-1:0]    OUT_CNT
);

  localparam int CW = cnt_width(DEPTH);

  logic [NUM_CHAN-1:0] push_en_s;
  logic [NUM_CHAN-1:0] full_s;
  logic [NUM_CHAN-1:0] empty_s;
  logic [CW-1:0]       cnt_s  [NUM_CHAN];
  logic [WIDTH-1:0]    head_s [NUM_CHAN];

  always_comb begin
    case (IN_SEL)
      2'd0:    IN_READY = ~full_s[0];
      2'd1:    IN_READY = ~full_s[1];
      2'd2:    IN_READY = ~full_s[2];
      2'd3:    IN_READY = ~full_s[3];
      default: IN_READY = 1'b0;
    endcase
  end

  always_comb begin
    push_en_s = '0;
    if (IN_VALID && IN_READY) begin
      case (IN_SEL)
        2'd0:    push_en_s = 4'b0001;
        2'd1:    push_en_s = 4'b0010;
        2'd2:    push_en_s = 4'b0100;
        2'd3:    push_en_s = 4'b1000;
        default: push_en_s = 4'b0000;
      endcase
    end else begin
      push_en_s = 4'b0000;
    end
  end

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push_en_s[k]),
      .push_data (IN_DATA),
      .pop       (OUT_READY[k]),
      .full      (full_s[k]),
      .empty     (empty_s[k]),
      .cnt       (cnt_s[k]),
      .head      (head_s[k])
    );
    assign OUT_VALID[k]          = ~empty_s[k];
    assign OUT_CNT[k*CW +: CW]   = cnt_s[k];
  end

  assign OUT_DATA0 = head_s[0];
  assign OUT_DATA1 = head_s[1];
  assign OUT_DATA2 = head_s[2];
  assign OUT_DATA3 = head_s[3];

endmodule

// File: tb/tb_demux_1t4_buf.sv
// Directed self-checking bench for demux_1t4_buf (WIDTH=32, DEPTH=2).
module tb_demux_1t4_buf;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  IN_SEL;
  logic [31:0] IN_DATA;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [31:0] OUT_DATA0;
  logic [31:0] OUT_DATA1;
  logic [31:0] OUT_DATA2;
  logic [31:0] OUT_DATA3;
  logic [7:0]  OUT_CNT;

  int total;
  int bad;
  int sent;
  int got;
  int cyc;
  logic [31:0] exp_q [$];

  demux_1t4_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_SEL    (IN_SEL),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA0 (OUT_DATA0),
    .OUT_DATA1 (OUT_DATA1),
    .OUT_DATA2 (OUT_DATA2),
    .OUT_DATA3 (OUT_DATA3),
    .OUT_CNT   (OUT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] get_data(input int k);
    case (k)
      0:       return OUT_DATA0;
      1:       return OUT_DATA1;
      2:       return OUT_DATA2;
      default: return OUT_DATA3;
    endcase
  endfunction

  function automatic logic [1:0] get_cnt(input int k);
    return OUT_CNT[k*2 +: 2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_SEL = 2'd0;
    IN_DATA = 32'h0;
    OUT_READY = 4'h0;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", OUT_VALID, 4'h0);
    check("rst_cnt", OUT_CNT, 8'h00);
    check("rst_data0", OUT_DATA0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      IN_SEL = k[1:0];
      #1;
      check("rst_ready", IN_READY, 1'b1);
    end
    RST = 1'b0;
    tick();
    check("idle_valid", OUT_VALID, 4'h0);
    check("idle_cnt", OUT_CNT, 8'h00);

    // one word per channel with consumers always ready
    OUT_READY = 4'hF;
    IN_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      IN_SEL = k[1:0];
      IN_DATA = 32'hA0 + k;
      #1;
      check("t2_ready", IN_READY, 1'b1);
      tick();
      check("t2_valid", OUT_VALID, 32'h1 << k);
      check("t2_data", get_data(k), 32'hA0 + k);
    end
    IN_VALID = 1'b0;
    tick();
    check("t2_drained", OUT_VALID, 4'h0);

    // fill channel 2, stall a third push, then drain in order
    OUT_READY = 4'h0;
    IN_VALID = 1'b1;
    IN_SEL = 2'd2;
    IN_DATA = 32'h11;
    tick();
    IN_DATA = 32'h22;
    tick();
    check("t3_cnt_full", get_cnt(2), 2'd2);
    check("t3_head", OUT_DATA2, 32'h11);
    check("t3_ready2", IN_READY, 1'b0);
    IN_SEL = 2'd0;
    #1;
    check("t3_ready0", IN_READY, 1'b1);
    IN_SEL = 2'd2;
    IN_DATA = 32'h33;
    tick();
    check("t3_stall_cnt", get_cnt(2), 2'd2);
    check("t3_stall_head", OUT_DATA2, 32'h11);
    OUT_READY = 4'b0100;
    tick();
    check("t3_pop1_head", OUT_DATA2, 32'h22);
    check("t3_pop1_cnt", get_cnt(2), 2'd1);
    check("t3_pop1_ready", IN_READY, 1'b1);
    tick();
    check("t3_pop2_head", OUT_DATA2, 32'h33);
    check("t3_pop2_cnt", get_cnt(2), 2'd1);
    IN_VALID = 1'b0;
    tick();
    check("t3_empty_cnt", get_cnt(2), 2'd0);
    check("t3_empty_valid", OUT_VALID, 4'h0);

    // simultaneous push and pop on a channel holding one word
    OUT_READY = 4'h0;
    IN_VALID = 1'b1;
    IN_SEL = 2'd1;
    IN_DATA = 32'h55;
    tick();
    check("t4_cnt1", get_cnt(1), 2'd1);
    check("t4_head1", OUT_DATA1, 32'h55);
    IN_DATA = 32'h66;
    OUT_READY = 4'b0010;
    tick();
    check("t4_cnt_same", get_cnt(1), 2'd1);
    check("t4_head_new", OUT_DATA1, 32'h66);
    check("t4_valid", OUT_VALID, 4'b0010);
    IN_VALID = 1'b0;
    tick();
    check("t4_drained", get_cnt(1), 2'd0);

    // eight beats through channel 3 with random back-pressure
    sent = 0;
    got = 0;
    cyc = 0;
    exp_q.delete();
    while (got < 8 && cyc < 200) begin
      IN_VALID = (sent < 8);
      IN_SEL = 2'd3;
      IN_DATA = 32'hC0 + sent;
      OUT_READY = {($urandom_range(0, 1) == 1), 3'b000};
      #1;
      check("t5_cnt", get_cnt(3), exp_q.size());
      check("t5_cnt_max", (get_cnt(3) <= 2'd2), 1'b1);
      if (OUT_VALID[3] && OUT_READY[3]) begin
        check("t5_data", OUT_DATA3, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
        got++;
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(IN_DATA);
        sent++;
      end
      tick();
      cyc++;
    end
    check("t5_got", got, 8);
    IN_VALID = 1'b0;
    OUT_READY = 4'h0;
    tick();
    check("t5_final_cnt", OUT_CNT, 8'h00);

    // fill every channel, then reset asynchronously mid-traffic
    IN_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        IN_SEL = k[1:0];
        IN_DATA = 32'hE0 + 2 * k + j;
        tick();
      end
    end
    check("t6_full_cnt", OUT_CNT, 8'hAA);
    check("t6_full_valid", OUT_VALID, 4'hF);
    IN_SEL = 2'd0;
    IN_DATA = 32'hFF;
    #2;
    RST = 1'b1;
    #1;
    check("t6_rst_valid", OUT_VALID, 4'h0);
    check("t6_rst_cnt", OUT_CNT, 8'h00);
    check("t6_rst_data1", OUT_DATA1, 32'h0);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      IN_SEL = k[1:0];
      IN_DATA = 32'hD0 + k;
      tick();
    end
    IN_VALID = 1'b0;
    check("t6_post_cnt", OUT_CNT, 8'h55);
    check("t6_post_valid", OUT_VALID, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check("t6_post_data", get_data(k), 32'hD0 + k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
